// File: rtl/prio_enc_pkg.sv
// Shared definitions for prio_drain_encoder.
//   ST_IDLE / ST_DRAIN : state encodings
//   msb_index()        : index of the highest set bit (vector zero-extended to MAX_N)
//   popcount()         : number of set bits (vector zero-extended to MAX_N)
// Both helpers work on MAX_N-wide vectors. Callers size-cast the argument up and
// the result down, so one definition serves every instance width up to MAX_N.
package prio_enc_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  localparam int MAX_N     = 256;
  localparam int MAX_IDX_W = 8;
  localparam int MAX_CNT_W = 9;

  // Only meaningful when vec has at least one bit set below n.
  function automatic logic [MAX_IDX_W-1:0] msb_index(input logic [MAX_N-1:0] vec, input int n);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && vec[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_N-1:0] vec);
    logic [MAX_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_N; i++) begin
      cnt = cnt + MAX_CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prio_drain_encoder_if.sv
// Request/response bundle for prio_drain_encoder.
//   req        : request vector into the encoder
//   out_valid  : encoder presents an index
//   out_ready  : consumer accepts the index
//   out_idx    : presented index
//   out_onehot : one-hot form of out_idx, zero when not valid
//   busy       : encoder is draining
//   pend_cnt   : number of requests still pending
// master = encoder side, slave = request source / consumer side.
interface prio_drain_encoder_if #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int CNT_W = $clog2(N + 1)
);
  logic [N-1:0]     req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     out_onehot;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;

  modport master (
    input  req, out_ready,
    output out_valid, out_idx, out_onehot, busy, pend_cnt
  );

  modport slave (
    output req, out_ready,
    input  out_valid, out_idx, out_onehot, busy, pend_cnt
  );
endinterface

// File: rtl/prio_msb_find.sv
// Combinational highest-set-bit finder.
//   vec   : input vector
//   idx   : index of the highest set bit (0 when vec is zero)
//   found : vec has at least one bit set
module prio_msb_find
  import prio_enc_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  assign idx   = IDX_W'(msb_index(MAX_N'(vec), N));
  assign found = |vec;

endmodule

// File: rtl/prio_drain_encoder.sv
// Registered priority encoder that captures a request vector and drains it one
// index per valid/ready handshake, highest index first.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : prio_drain_encoder_if.master (req in, indexed output stream out)
// Optional build macro PRIO_DRAIN_STICKY_EN: requests arriving during DRAIN are
// merged into the pending set instead of being ignored.
// N is limited to prio_enc_pkg::MAX_N.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nothing pending; captures req on the first edge it is nonzero
// DRAIN  | out_valid high; out_idx = highest pending bit, held until accepted
module prio_drain_encoder
  import prio_enc_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst_n,
  prio_drain_encoder_if.master bus
);

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_DRAIN = ST_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [N-1:0]     sel_oh;
  logic [N-1:0]     clr_vec;
  logic [N-1:0]     pend_next;
  logic             hs;
  logic [IDX_W-1:0] req_idx, nxt_idx;
  logic             req_found, nxt_found;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N; i++) begin
      sel_oh[i] = (idx_q == IDX_W'(i));
    end
  end

  // Pending set as it will look after this edge while draining.
  always_comb begin
    hs      = (state_q == S_DRAIN) && bus.out_ready;
    clr_vec = hs ? sel_oh : '0;
`ifdef PRIO_DRAIN_STICKY_EN
    // req is OR-ed after the clear so a bit re-asserted as it is accepted survives.
    pend_next = (pending_q & ~clr_vec) | bus.req;
`else
    pend_next = pending_q & ~clr_vec;
`endif
  end

  prio_msb_find #(.N(N), .IDX_W(IDX_W)) u_find_req (
    .vec   (bus.req),
    .idx   (req_idx),
    .found (req_found)
  );

  prio_msb_find #(.N(N), .IDX_W(IDX_W)) u_find_nxt (
    .vec   (pend_next),
    .idx   (nxt_idx),
    .found (nxt_found)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          pending_d = bus.req;
          idx_d     = req_idx;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pending_d = pend_next;
        // out_idx only moves on a handshake, so a stalled index never changes.
        if (hs) begin
          if (nxt_found) idx_d = nxt_idx;
          else           state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.out_valid  = (state_q == S_DRAIN);
  assign bus.busy       = (state_q == S_DRAIN);
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = (state_q == S_DRAIN) ? sel_oh : '0;
  assign bus.pend_cnt   = CNT_W'(popcount(MAX_N'(pending_q)));

endmodule

// File: tb/tb_prio_drain_encoder.sv
// Bench for prio_drain_encoder: N=4 main instance plus N=1 and N=16 instances.
// Expected handshakes are queued by the stimulus; per-instance monitors pop and
// compare on every cycle where out_valid && out_ready.
module tb_prio_drain_encoder;
  import prio_enc_pkg::*;

  typedef struct {
    int idx;
    int cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q16[$];

  prio_drain_encoder_if #(.N(4))  bus4 ();
  prio_drain_encoder_if #(.N(1))  bus1 ();
  prio_drain_encoder_if #(.N(16)) bus16 ();

  prio_drain_encoder #(.N(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  prio_drain_encoder #(.N(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  prio_drain_encoder #(.N(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int idx, input int cnt);
    exp_t e;
    e.idx = idx;
    e.cnt = cnt;
    q4.push_back(e);
  endtask

  // ---------------- monitors ----------------
  logic       prev_stall4 = 1'b0;
  logic [1:0] prev_idx4   = '0;

  always @(negedge clk) begin
    exp_t e;
    if (bus4.out_valid === 1'b1 && bus4.out_ready === 1'b1) begin
      tests++;
      if (q4.size() == 0) begin
        fails++;
        $display("FAIL n4_unexpected_hs: got idx %0d, expected no handshake", bus4.out_idx);
      end else begin
        tests--;
        e = q4.pop_front();
        check("n4_idx", 32'(bus4.out_idx), e.idx);
        check("n4_onehot", 32'(bus4.out_onehot), 32'd1 << e.idx);
        check("n4_pend_cnt", 32'(bus4.pend_cnt), e.cnt);
      end
    end
    if (prev_stall4 && bus4.out_valid === 1'b1)
      check("n4_hold_idx", 32'(bus4.out_idx), 32'(prev_idx4));
    prev_stall4 = (bus4.out_valid === 1'b1) && (bus4.out_ready === 1'b0);
    prev_idx4   = bus4.out_idx;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL n1_unexpected_hs: got idx %0d, expected no handshake", bus1.out_idx);
      end else begin
        tests--;
        e = q1.pop_front();
        check("n1_idx", 32'(bus1.out_idx), e.idx);
        check("n1_onehot", 32'(bus1.out_onehot), 32'd1 << e.idx);
        check("n1_pend_cnt", 32'(bus1.pend_cnt), e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus16.out_valid === 1'b1 && bus16.out_ready === 1'b1) begin
      tests++;
      if (q16.size() == 0) begin
        fails++;
        $display("FAIL n16_unexpected_hs: got idx %0d, expected no handshake", bus16.out_idx);
      end else begin
        tests--;
        e = q16.pop_front();
        check("n16_idx", 32'(bus16.out_idx), e.idx);
        check("n16_onehot", 32'(bus16.out_onehot), 32'd1 << e.idx);
        check("n16_pend_cnt", 32'(bus16.pend_cnt), e.cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    rst_n           = 1'b0;
    bus4.req        = 4'b1111;
    bus4.out_ready  = 1'b0;
    bus1.req        = 1'b0;
    bus1.out_ready  = 1'b0;
    bus16.req       = '0;
    bus16.out_ready = 1'b0;

    // 1: reset held two cycles with all requests high
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", 32'(bus4.out_valid), 0);
      check("rst_onehot", 32'(bus4.out_onehot), 0);
      check("rst_busy", 32'(bus4.busy), 0);
      check("rst_cnt", 32'(bus4.pend_cnt), 0);
    end
    rst_n    = 1'b1;
    bus4.req = 4'b0000;
    tick();
    check("idle_valid", 32'(bus4.out_valid), 0);

    // 2: 1011 drained with ready=1 -> 3,1,0
    push4(3, 3);
    push4(1, 2);
    push4(0, 1);
    bus4.req       = 4'b1011;
    bus4.out_ready = 1'b1;
    tick();
    bus4.req = 4'b0000;
    check("t2_valid_lat1", 32'(bus4.out_valid), 1);
    tick();
    tick();
    tick();
    check("t2_end_valid", 32'(bus4.out_valid), 0);
    check("t2_end_busy", 32'(bus4.busy), 0);
    check("t2_end_cnt", 32'(bus4.pend_cnt), 0);

    // 3: backpressure on 0110
    bus4.out_ready = 1'b0;
    bus4.req       = 4'b0110;
    tick();
    bus4.req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_idx", 32'(bus4.out_idx), 2);
      check("t3_stall_onehot", 32'(bus4.out_onehot), 32'b0100);
      tick();
    end
    push4(2, 2);
    push4(1, 1);
    bus4.out_ready = 1'b1;
    tick();
    check("t3_second_idx", 32'(bus4.out_idx), 1);
    tick();
    check("t3_end_busy", 32'(bus4.busy), 0);

    // 4: reset after one handshake
    push4(3, 4);
    bus4.req = 4'b1111;
    tick();
    bus4.req = 4'b0000;
    tick();
    check("t4_after_hs_idx", 32'(bus4.out_idx), 2);
    rst_n          = 1'b0;
    bus4.out_ready = 1'b0;
    tick();
    rst_n          = 1'b1;
    bus4.out_ready = 1'b1;
    check("t4_rst_valid", 32'(bus4.out_valid), 0);
    check("t4_rst_cnt", 32'(bus4.pend_cnt), 0);
    tick();
    tick();
    check("t4_still_idle", 32'(bus4.busy), 0);

    // 5: late request while stalled on idx 0
    bus4.out_ready = 1'b0;
    bus4.req       = 4'b0001;
    tick();
    bus4.req = 4'b1000;
    tick();
    bus4.req = 4'b0000;
    check("t5_stalled_idx", 32'(bus4.out_idx), 0);
`ifdef PRIO_DRAIN_STICKY_EN
    check("t5_merged_cnt", 32'(bus4.pend_cnt), 2);
    push4(0, 2);
    push4(3, 1);
`else
    check("t5_merged_cnt", 32'(bus4.pend_cnt), 1);
    push4(0, 1);
`endif
    bus4.out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("t5_end_busy", 32'(bus4.busy), 0);
    check("t5_end_cnt", 32'(bus4.pend_cnt), 0);

    // 6a: N=1
    bus1.req = 1'b1;
    tick();
    bus1.req = 1'b0;
    check("n1_valid_lat1", 32'(bus1.out_valid), 1);
    check("n1_idx_zero", 32'(bus1.out_idx), 0);
    e.idx = 0;
    e.cnt = 1;
    q1.push_back(e);
    bus1.out_ready = 1'b1;
    tick();
    check("n1_end_valid", 32'(bus1.out_valid), 0);
    check("n1_end_busy", 32'(bus1.busy), 0);

    // 6b: N=16, 0x8421 -> 15,10,5,0
    e.idx = 15; e.cnt = 4; q16.push_back(e);
    e.idx = 10; e.cnt = 3; q16.push_back(e);
    e.idx = 5;  e.cnt = 2; q16.push_back(e);
    e.idx = 0;  e.cnt = 1; q16.push_back(e);
    bus16.req       = 16'h8421;
    bus16.out_ready = 1'b1;
    tick();
    bus16.req = '0;
    check("n16_first_idx", 32'(bus16.out_idx), 15);
    for (int i = 0; i < 4; i++) tick();
    check("n16_end_busy", 32'(bus16.busy), 0);

    tick();
    tick();
    check("q4_drained", q4.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q16_drained", q16.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
